// File: rtl/armv4_ram_resp.sv
// armv4core data-memory responder: four byte-lane banks with
// one-cycle registered reads, unaligned/wrapping access and a
// sticky write-protect window over [0, PROT_SIZE).
//
// Ports:
//   clk, rst          clock, async active-high reset
//   i_ram_en/wr       access request / 1=write
//   i_ram_size        MEM_B byte, MEM_H half, else word
//   i_ram_addr        byte address (aliases above ADDR_WIDTH)
//   i_ram_wdata       right-aligned write data
//   o_ram_rdata       registered, zero-extended read data
//   i_prot_en         enable write-protect window
//   i_fault_clr       clear sticky fault flag
//   o_fault           sticky protect-violation flag
//   o_fault_addr      address of first violation since clear
module armv4_ram_resp #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] PROT_SIZE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ram_en,
  input  logic        i_ram_wr,
  input  logic [1:0]  i_ram_size,
  input  logic [31:0] i_ram_addr,
  input  logic [31:0] i_ram_wdata,
  output logic [31:0] o_ram_rdata,
  input  logic        i_prot_en,
  input  logic        i_fault_clr,
  output logic        o_fault,
  output logic [31:0] o_fault_addr
);

  // def.v size encodings
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;

  localparam int RW   = ADDR_WIDTH - 2;
  localparam int ROWS = 1 << RW;

  logic [ADDR_WIDTH-1:0] ea;
  logic [1:0]            off;
  logic [2:0]            len;

  assign ea  = i_ram_addr[ADDR_WIDTH-1:0];
  assign off = ea[1:0];

  always_comb begin
    case (i_ram_size)
      MEM_B:   len = 3'd1;
      MEM_H:   len = 3'd2;
      default: len = 3'd4;
    endcase
  end

  // Per data-byte k: its wrapped address, whether it is
  // covered by this access, and whether it is protected.
  logic [ADDR_WIDTH-1:0] baddr [4];
  logic [7:0]            wbyte [4];
  logic [3:0]            cov;
  logic [3:0]            in_win;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      baddr[k]  = ea + ADDR_WIDTH'(k);
      cov[k]    = 3'(k) < len;
      in_win[k] = 32'(baddr[k]) < PROT_SIZE;
      wbyte[k]  = i_ram_wdata[8*k +: 8];
    end
  end

  logic viol;
  logic wr_go;
  logic rd_go;

  assign viol  = i_ram_en & i_ram_wr & i_prot_en
               & (|(cov & in_win));
  // A violating write is dropped on every lane; an access
  // coinciding with reset is discarded.
  assign wr_go = i_ram_en & i_ram_wr & ~rst & ~viol;
  assign rd_go = i_ram_en & ~i_ram_wr;

  // Per lane j: which data byte it carries and its own row,
  // so an unaligned access may span two rows (or wrap).
  logic [1:0]    lane_k   [4];
  logic [RW-1:0] lane_row [4];
  logic [3:0]    lane_we;
  logic [7:0]    lane_wd  [4];
  logic [7:0]    lane_rd  [4];

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      lane_k[j]   = 2'(j) - off;
      lane_row[j] = baddr[lane_k[j]][ADDR_WIDTH-1:2];
      lane_we[j]  = wr_go & cov[lane_k[j]];
      lane_wd[j]  = wbyte[lane_k[j]];
    end
  end

  // Storage has no reset so contents survive rst.
  for (genvar j = 0; j < 4; j++) begin : g_lane
    logic [7:0] mem [ROWS];

    always_ff @(posedge clk) begin
      if (lane_we[j])
        mem[lane_row[j]] <= lane_wd[j];
    end

    assign lane_rd[j] = mem[lane_row[j]];
  end

  // Data byte k comes from lane (off+k) mod 4.
  logic [1:0]  rd_lane [4];
  logic [31:0] rd_next;

  always_comb begin
    rd_next = '0;
    for (int k = 0; k < 4; k++) begin
      rd_lane[k] = off + 2'(k);
      if (cov[k])
        rd_next[8*k +: 8] = lane_rd[rd_lane[k]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ram_rdata <= '0;
    end else if (rd_go) begin
      o_ram_rdata <= rd_next;
    end
  end

  // Set beats clear; a same-cycle clear makes this violation
  // count as a fresh first fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_fault      <= 1'b0;
      o_fault_addr <= '0;
    end else if (viol) begin
      o_fault <= 1'b1;
      if (!o_fault || i_fault_clr)
        o_fault_addr <= i_ram_addr;
    end else if (i_fault_clr) begin
      o_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_armv4_ram_resp.sv
// Directed bench for armv4_ram_resp: aligned, partial,
// unaligned/wrap, hold, alias, protection and reset cases.
module tb_armv4_ram_resp;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        prot_en;
  logic        fault_clr;
  logic        fault;
  logic [31:0] fault_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  armv4_ram_resp dut (
    .clk          (clk),
    .rst          (rst),
    .i_ram_en     (en),
    .i_ram_wr     (wr),
    .i_ram_size   (size),
    .i_ram_addr   (addr),
    .i_ram_wdata  (wdata),
    .o_ram_rdata  (rdata),
    .i_prot_en    (prot_en),
    .i_fault_clr  (fault_clr),
    .o_fault      (fault),
    .o_fault_addr (fault_addr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic        w,
                     input logic [1:0]  s,
                     input logic [31:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    en    = 1'b1;
    wr    = w;
    size  = s;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    en        = 1'b0;
    wr        = 1'b0;
    fault_clr = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    wr        = 1'b0;
    size      = SW;
    addr      = '0;
    wdata     = '0;
    prot_en   = 1'b0;
    fault_clr = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_faddr", fault_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // aligned
    acc(1, SW, 32'h2000, 32'h89AB_CDEF);
    acc(0, SW, 32'h2000, 0);
    chk("w_2000", rdata, 32'h89AB_CDEF);
    acc(0, SH, 32'h2002, 0);
    chk("h_2002", rdata, 32'h0000_89AB);
    acc(0, SB, 32'h2001, 0);
    chk("b_2001", rdata, 32'h0000_00CD);

    // partial lanes
    acc(1, SB, 32'h2003, 32'hFFFF_FF55);
    acc(0, SW, 32'h2000, 0);
    chk("b_wr_lane", rdata, 32'h55AB_CDEF);
    acc(1, SH, 32'h2000, 32'hFFFF_1234);
    acc(0, SW, 32'h2000, 0);
    chk("h_wr_lane", rdata, 32'h55AB_1234);

    // unaligned and wrap
    acc(1, SW, 32'h3001, 32'h0123_4567);
    acc(0, SB, 32'h3001, 0);
    chk("ua_b3001", rdata, 32'h67);
    acc(0, SB, 32'h3004, 0);
    chk("ua_b3004", rdata, 32'h01);
    acc(0, SW, 32'h3001, 0);
    chk("ua_w3001", rdata, 32'h0123_4567);
    acc(0, SH, 32'h3003, 0);
    chk("ua_h3003", rdata, 32'h0000_0123);
    acc(1, SW, 32'hFFFE, 32'hA1B2_C3D4);
    acc(0, SB, 32'hFFFE, 0);
    chk("wr_fffe", rdata, 32'hD4);
    acc(0, SB, 32'hFFFF, 0);
    chk("wr_ffff", rdata, 32'hC3);
    acc(0, SB, 32'h0000, 0);
    chk("wr_0000", rdata, 32'hB2);
    acc(0, SB, 32'h0001, 0);
    chk("wr_0001", rdata, 32'hA1);
    acc(0, SW, 32'hFFFE, 0);
    chk("wr_wfffe", rdata, 32'hA1B2_C3D4);

    // read hold
    acc(0, SW, 32'h2000, 0);
    chk("hold_rd", rdata, 32'h55AB_1234);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("hold_idle", rdata, 32'h55AB_1234);
    end
    acc(1, SW, 32'h2000, 32'hFEED_FACE);
    chk("hold_wr", rdata, 32'h55AB_1234);
    acc(0, SW, 32'h0001_2000, 0);
    chk("alias", rdata, 32'hFEED_FACE);
    acc(0, SW, 32'h2000, 0);
    chk("alias_base", rdata, 32'hFEED_FACE);

    // protection
    acc(1, SW, 32'h0FFE, 32'h1122_3344);
    prot_en = 1'b1;
    acc(1, SW, 32'h0FFE, 32'hDEAD_BEEF);
    chk("pv_fault", 32'(fault), 32'h1);
    chk("pv_faddr", fault_addr, 32'h0FFE);
    acc(0, SW, 32'h0FFE, 0);
    chk("pv_mem", rdata, 32'h1122_3344);
    acc(1, SW, 32'h0100, 32'h0);
    chk("pv2_faddr", fault_addr, 32'h0FFE);
    acc(1, SW, 32'h1000, 32'hCAFE_F00D);
    acc(0, SW, 32'h1000, 0);
    chk("pv_ok_1000", rdata, 32'hCAFE_F00D);
    chk("pv_ok_flt", 32'(fault), 32'h1);
    fault_clr = 1'b1;
    idle();
    chk("clr_fault", 32'(fault), 32'h0);
    chk("clr_faddr", fault_addr, 32'h0FFE);
    fault_clr = 1'b1;
    acc(1, SW, 32'h0200, 32'h0);
    chk("clrset_flt", 32'(fault), 32'h1);
    chk("clrset_fa", fault_addr, 32'h0200);
    fault_clr = 1'b1;
    idle();
    acc(1, SW, 32'h0001_FFFE, 32'h0);
    chk("wrapv_flt", 32'(fault), 32'h1);
    chk("wrapv_fa", fault_addr, 32'h0001_FFFE);
    acc(0, SW, 32'hFFFE, 0);
    chk("wrapv_mem", rdata, 32'hA1B2_C3D4);
    prot_en = 1'b0;

    // reset mid-read
    acc(0, SW, 32'h1000, 0);
    @(negedge clk);
    en   = 1'b1;
    wr   = 1'b0;
    size = SW;
    addr = 32'h2000;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_rdata", rdata, 32'h0);
    chk("mrst_fault", 32'(fault), 32'h0);
    chk("mrst_faddr", fault_addr, 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acc(0, SW, 32'h2000, 0);
    chk("post_rst", rdata, 32'hFEED_FACE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
